// File: rtl/half2_decim.sv
`default_nettype none
// ============================================================================
// Module   : half2_decim
// Purpose  : Two-channel 2:1 half-band decimating FIR, shift/add only.
//            Each channel is filtered with [-1 0 9 16 9 0 -1]/16 (DC gain 2),
//            rounded half up, and the two results share output d, selected
//            by the phase input ab.
// Ports    : clk    - single rising-edge clock
//            rst_n  - synchronous reset, active low
//            a      - channel A sample (signed, DW bits, one per clock)
//            b      - channel B sample (signed, DW bits, one per clock)
//            ab     - phase select: 0 shows channel A, 1 shows channel B
//            d      - registered filtered output (signed, OW bits)
// Config   : HALF2_SAT_EN defined   -> result clamped to the OW-bit range
//            HALF2_SAT_EN undefined -> result wraps to OW bits
// Revision : 1.0  initial release
// ============================================================================
module half2_decim #(
  parameter int DW = 16,
  parameter int OW = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic                 ab,
  output logic signed [OW-1:0] d
);

  localparam int C_NT = 7;       // taps / delay-line depth
  localparam int C_SW = DW + 6;  // accumulator width, holds worst-case sum

  localparam logic signed [C_SW-1:0] C_RND   = C_SW'(8);
  localparam logic signed [C_SW-1:0] C_Y_MAX = C_SW'((1 << (OW-1)) - 1);
  localparam logic signed [C_SW-1:0] C_Y_MIN = C_SW'(-(1 << (OW-1)));

  // Per-channel state, index 0 = A, 1 = B.
  // dl_q[ch][i] holds x[k-i] after the edge that captured x[k].
  logic signed [DW-1:0]   dl_q [2][C_NT];
  logic signed [DW-1:0]   dl_d [2][C_NT];
  // Stage 1: symmetric pair sums and centre tap.
  logic signed [DW:0]     ev_q [2];   // x[k-2] + x[k-4]
  logic signed [DW:0]     ev_d [2];
  logic signed [DW:0]     od_q [2];   // x[k]   + x[k-6]
  logic signed [DW:0]     od_d [2];
  logic signed [DW-1:0]   ct_q [2];   // x[k-3]
  logic signed [DW-1:0]   ct_d [2];
  // Stage 2: full-precision filter sum.
  logic signed [C_SW-1:0] s_q  [2];
  logic signed [C_SW-1:0] s_d  [2];
  // Stage 3: rounded, range-handled, multiplexed output.
  logic signed [OW-1:0]   d_q;
  logic signed [OW-1:0]   d_d;

  logic signed [C_SW-1:0] w_rnd;
  logic signed [C_SW-1:0] w_y;

  always_comb begin
    dl_d[0][0] = a;
    dl_d[1][0] = b;
    for (int ch = 0; ch < 2; ch++) begin
      for (int i = 1; i < C_NT; i++) begin
        dl_d[ch][i] = dl_q[ch][i-1];
      end
      ev_d[ch] = (DW+1)'(dl_q[ch][2]) + (DW+1)'(dl_q[ch][4]);
      od_d[ch] = (DW+1)'(dl_q[ch][0]) + (DW+1)'(dl_q[ch][6]);
      ct_d[ch] = dl_q[ch][3];
      // 9*ev + 16*ct - od, with 9x built as (x<<3)+x.
      s_d[ch]  = (C_SW'(ev_q[ch]) <<< 3) + C_SW'(ev_q[ch])
               + (C_SW'(ct_q[ch]) <<< 4) - C_SW'(od_q[ch]);
    end

    // Select the channel first so a single rounder serves both.
    w_rnd = (ab ? s_q[1] : s_q[0]) + C_RND;
    w_y   = w_rnd >>> 4;

`ifdef HALF2_SAT_EN
    if (w_y > C_Y_MAX) begin
      d_d = OW'(C_Y_MAX);
    end else if (w_y < C_Y_MIN) begin
      d_d = OW'(C_Y_MIN);
    end else begin
      d_d = OW'(w_y);
    end
`else
    d_d = OW'(w_y);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int i = 0; i < C_NT; i++) begin
          dl_q[ch][i] <= '0;
        end
        ev_q[ch] <= '0;
        od_q[ch] <= '0;
        ct_q[ch] <= '0;
        s_q[ch]  <= '0;
      end
      d_q <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int i = 0; i < C_NT; i++) begin
          dl_q[ch][i] <= dl_d[ch][i];
        end
        ev_q[ch] <= ev_d[ch];
        od_q[ch] <= od_d[ch];
        ct_q[ch] <= ct_d[ch];
        s_q[ch]  <= s_d[ch];
      end
      d_q <= d_d;
    end
  end

  assign d = d_q;

endmodule
`default_nettype wire

// File: tb/tb_half2_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_half2_decim
// Purpose  : Scoreboard bench for half2_decim. A driver applies stimulus on
//            the falling edge and pushes the expected d for the next rising
//            edge; a monitor pops and compares just after each rising edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_half2_decim;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] a     = '0;
  logic signed [15:0] b     = '0;
  logic               ab    = 1'b0;
  logic signed [16:0] d;

  always #5 clk = ~clk;

  half2_decim #(.DW(16), .OW(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .ab    (ab),
    .d     (d)
  );

  // Reference model: sample history (index 0 = newest) and the last three
  // filter results per channel, since d shows y[k-3] at edge k.
  int xa [7];
  int xb [7];
  int ya [3];
  int yb [3];
  int exp_q [$];
  int checks = 0;
  int errors = 0;
  bit ph = 1'b0;

  function automatic int filt(input int x0, input int x2, input int x3,
                              input int x4, input int x6);
    int s;
    int y;
    s = -x0 + 9*x2 + 16*x3 + 9*x4 - x6;
    y = (s + 8) >>> 4;
`ifdef HALF2_SAT_EN
    if (y > 65535)  y = 65535;
    if (y < -65536) y = -65536;
`else
    y = y & 32'h1FFFF;
    if (y >= 65536) y = y - 131072;
`endif
    return y;
  endfunction

  task automatic drive(input int va, input int vb, input bit vab, input bit vrst_n);
    int e;
    @(negedge clk);
    a     = 16'(va);
    b     = 16'(vb);
    ab    = vab;
    rst_n = vrst_n;
    if (!vrst_n) begin
      for (int i = 0; i < 7; i++) begin xa[i] = 0; xb[i] = 0; end
      for (int i = 0; i < 3; i++) begin ya[i] = 0; yb[i] = 0; end
      exp_q.push_back(0);
    end else begin
      for (int i = 6; i > 0; i--) begin xa[i] = xa[i-1]; xb[i] = xb[i-1]; end
      xa[0] = va;
      xb[0] = vb;
      e = vab ? yb[2] : ya[2];
      ya[2] = ya[1]; ya[1] = ya[0];
      yb[2] = yb[1]; yb[1] = yb[0];
      ya[0] = filt(xa[0], xa[2], xa[3], xa[4], xa[6]);
      yb[0] = filt(xb[0], xb[2], xb[3], xb[4], xb[6]);
      exp_q.push_back(e);
    end
  endtask

  // Normal running cycle: ab toggles every clock.
  task automatic tick(input int va, input int vb);
    drive(va, vb, ph, 1'b1);
    ph = ~ph;
  endtask

  // Monitor
  always @(posedge clk) begin
    int e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ($isunknown(d) || int'(d) != e) begin
        errors++;
        $display("FAIL d_check #%0d at %0t: got %0d expected %0d (ab=%0d)",
                 checks, $time, int'(d), e, ab);
      end
    end
  end

  int ext [2];

  initial begin
    ext[0] = 32767;
    ext[1] = -32768;

    // 1: reset held with non-zero inputs, then release.
    for (int i = 0; i < 3; i++) begin
      drive(1234, 1234, ph, 1'b0);
      ph = ~ph;
    end
    tick(1234, 1234);
    for (int i = 0; i < 10; i++) tick(0, 0);

    // 2: impulse on A in an ab=0 cycle.
    if (ph) tick(0, 0);
    tick(1024, 0);
    for (int i = 0; i < 12; i++) tick(0, 0);

    // 3: impulse on A in an ab=1 cycle.
    if (!ph) tick(0, 0);
    tick(1024, 0);
    for (int i = 0; i < 12; i++) tick(0, 0);

    // 4: sinusoid on B.
    for (int n = 0; n < 70; n++) begin
      tick(0, int'(30000.0 * $sin(0.1596 * n)));
    end

    // 5: full-scale constants.
    for (int i = 0; i < 12; i++) tick(32767, 32767);
    for (int i = 0; i < 12; i++) tick(-32768, -32768);

    // 6: extreme values, driving y beyond the output range.
    for (int i = 0; i < 160; i++) begin
      tick(ext[$urandom_range(1)], ext[$urandom_range(1)]);
    end

    // 7: random full-range data, occasional missed toggle and mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 3) begin
        drive($urandom_range(65535) - 32768, $urandom_range(65535) - 32768, ph, 1'b0);
        ph = ~ph;
      end else if ($urandom_range(99) < 10) begin
        drive($urandom_range(65535) - 32768, $urandom_range(65535) - 32768, ph, 1'b1);
      end else begin
        tick($urandom_range(65535) - 32768, $urandom_range(65535) - 32768);
      end
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
